// File: rtl/mem_ctrl.sv
// Word-addressed memory with a wait-state handshake controller: latches one request,
// waits WAIT_STATES cycles, then touches the array and pulses done.
module mem_ctrl #(
    parameter int AW          = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data_in,
    output logic [31:0]   mdatain,
    output logic          done,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_data;
    logic          lat_wr;
    logic          mem_we;

    logic [31:0]   mem [2**AW];

    // Array write is gated by clr so a reset edge aborts a pending commit.
    always_comb mem_we = clr && (state == ACCESS) && (cnt == '0) && lat_wr;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[lat_addr] <= lat_data;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= IDLE;
            cnt     <= '0;
            mdatain <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (read && write) begin
                        err <= 1'b1;
                    end else if (read || write) begin
                        lat_addr <= addr;
                        lat_wr   <= write;
                        if (write)
                            lat_data <= data_in;
                        cnt   <= 4'(WAIT_STATES);
                        state <= ACCESS;
                        busy  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!lat_wr)
                            mdatain <= mem[lat_addr];
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against an array-based transaction model.
module tb_mem_ctrl;

    localparam int AW = 9;
    localparam int WS = 2;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   mdatain;
    logic          done;
    logic          busy;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_md;

    mem_ctrl #(.AW(AW), .WAIT_STATES(WS)) dut (
        .clk     (clk),
        .clr     (clr),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .data_in (data_in),
        .mdatain (mdatain),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"},  32'(err),  32'd0);
        check({tag, "_md"},   mdatain,   ref_md);
    endtask

    // One transaction; the model expects done exactly WS+1 edges after the request edge.
    task automatic do_op(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input bit scramble, input bit inject);
        int n;
        int dones;
        bit seen;
        logic [31:0] md_at_done;
        @(negedge clk);
        read = !wr; write = wr; addr = a; data_in = d;
        @(posedge clk);
        if (wr) ref_mem[a] = d;
        else    ref_md = ref_mem[a];
        #1;
        check("busy_e0", 32'(busy), 32'd1);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        if (scramble) begin
            addr = AW'($urandom);
            data_in = $urandom;
        end
        if (inject) begin
            write = 1'b1; addr = 9'h020; data_in = 32'h12345678;
        end
        n = 0; dones = 0; seen = 1'b0; md_at_done = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (inject && i == 1) write = 1'b0;
            if (i <= WS + 1) check("busy_wait", 32'(busy), 32'd1);
            if (done) begin
                dones++;
                if (!seen) begin
                    seen = 1'b1;
                    n = i;
                    md_at_done = mdatain;
                end
            end
            if (seen && i == n + 1) break;
        end
        check("done_lat", 32'(n), 32'(WS + 1));
        check("done_cnt", 32'(dones), 32'd1);
        check("rdata", md_at_done, ref_md);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd0);
    endtask

    task automatic do_conflict();
        @(negedge clk);
        read = 1'b1; write = 1'b1; addr = AW'($urandom); data_in = $urandom;
        @(posedge clk);
        #1;
        check("cf_err", 32'(err), 32'd1);
        check("cf_busy", 32'(busy), 32'd0);
        check("cf_done", 32'(done), 32'd0);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        @(posedge clk);
        #1;
        check_idle("cf_after");
    endtask

    initial begin
        ref_md = '0;

        // Reset held for two edges, then five idle cycles.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_idle("rst");
        end
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_idle("idle");
        end

        // Preload the whole array so every later read has a known value.
        for (int i = 0; i < DEPTH; i++)
            do_op(1'b1, AW'(i), $urandom, 1'b0, 1'b0);

        do_op(1'b1, 9'h005, 32'hDEADBEEF, 1'b0, 1'b0);
        do_op(1'b0, 9'h005, 32'h0, 1'b0, 1'b0);
        check("raw_5", mdatain, 32'hDEADBEEF);

        do_op(1'b0, 9'h010, 32'h0, 1'b1, 1'b0);

        do_op(1'b0, 9'h040, 32'h0, 1'b0, 1'b1);
        do_op(1'b0, 9'h020, 32'h0, 1'b0, 1'b0);

        do_conflict();

        // Reset at E0+1 aborts a pending write to the top address.
        @(negedge clk);
        write = 1'b1; addr = 9'h1FF; data_in = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0; clr = 1'b0;
        ref_md = '0;
        @(posedge clk);
        #1;
        check_idle("abort");
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_idle("post_abort");
        end
        do_op(1'b0, 9'h1FF, 32'h0, 1'b0, 1'b0);
        do_op(1'b1, 9'h1FF, 32'h0BADF00D, 1'b0, 1'b0);
        do_op(1'b0, 9'h1FF, 32'h0, 1'b0, 1'b0);
        check("top_rd", mdatain, 32'h0BADF00D);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0)
                do_conflict();
            else
                do_op(1'($urandom), AW'($urandom), $urandom,
                      1'($urandom), ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
